seq_multiplier: RTL and testbench

Iterative 32×32→64 multiplier for MULT/MULTU, sitting directly upstream of the HI/LO register. It accepts two operands on a start pulse and runs a radix-2 shift-add loop over 32 cycles. It then presents the 64-bit product on `MulAns` with a one-cycle `done` strobe, which the control path uses to enable the HI/LO write. It also drives `busy`, which the hazard unit uses to stall MFHI/MFLO and further multiplies.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/seq_multiplier.sv | 62 ++++++
 tb/tb_seq_multiplier.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, word width and multiply funct codes
package cpu_pkg;
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
    localparam int WORD_W = 32;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add 32x32->64 multiplier for MULT/MULTU feeding HI/LO
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] MulAns
);
    localparam int CW = $clog2(WIDTH);
    mul_state_t state, next;
    logic [WIDTH-1:0] mcand, mplier, abs_a, abs_b;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH:0] sum;
    logic [CW-1:0] cnt;
    logic neg, accept, last;
    assign accept = start && state != MUL_RUN;
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state == MUL_RUN;
    assign done = state == MUL_DONE;
    assign abs_a = signed_op && dataA[WIDTH-1] ? -dataA : dataA;
    assign abs_b = signed_op && dataB[WIDTH-1] ? -dataB : dataB;
    // carry of the upper-half add shifts into the top bit of acc
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
    assign acc_nxt = {sum, acc[WIDTH-1:1]};
    always_comb begin
        next = state;
        next = accept ? MUL_RUN : state == MUL_RUN ? (last ? MUL_DONE : MUL_RUN) : MUL_IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MUL_IDLE;
        else state <= next;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            mplier <= '0;
            neg <= 1'b0;
            acc <= '0;
            cnt <= '0;
            MulAns <= '0;
        end else if (accept) begin
            mcand <= abs_a;
            mplier <= abs_b;
            neg <= (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & signed_op;
            acc <= '0;
            cnt <= '0;
        end else if (state == MUL_RUN) begin
            acc <= acc_nxt;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
            if (last) MulAns <= neg ? -acc_nxt : acc_nxt;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized scoreboard bench against an arithmetic product model
module tb_seq_multiplier;
    logic clk = 0, reset = 0, start = 0, signed_op = 0;
    logic [31:0] dataA = '0, dataB = '0;
    logic busy, done;
    logic [63:0] MulAns, last_exp;
    logic prev_done = 0;
    logic [63:0] exp_q[$];
    int vectors = 0, miscompares = 0;

    seq_multiplier dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .MulAns(MulAns)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endfunction

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return s ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            chk("done_single_cycle", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else chk("product", MulAns, exp_q.pop_front());
        end
        prev_done = done;
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1; dataA = a; dataB = b; signed_op = s;
        @(posedge clk);
        last_exp = model(a, b, s);
        exp_q.push_back(last_exp);
        #1 start = 0;
    endtask

    // walks the 33 negedges after the start edge; poke>0 injects a start during RUN
    task automatic track(input int poke);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (i == poke) begin
                start = 1; dataA = 32'h1234; dataB = 32'h5678; signed_op = 0;
            end
            if (i == poke + 1) start = 0;
            if (i < 33) chk("busy_run", {62'd0, busy, done}, 64'd2);
            else chk("done_at_e32", {62'd0, busy, done}, 64'd1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, MulAns[61:0]}, 64'd0);
        reset = 1;
        @(negedge clk);
        chk("idle_after_reset", {62'd0, busy, done}, 64'd0);
        launch(32'h3, 32'h5, 0); track(0);
        @(negedge clk);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 0); track(0);
        @(negedge clk);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1); track(0);
        @(negedge clk);
        launch(32'hFFFFFFFF, 32'h1, 1); track(0);
        @(negedge clk);
        launch(32'h80000000, 32'h80000000, 1); track(0);
        @(negedge clk);
        launch(32'hFFFFFFFB, 32'h0, 1); track(0);
        @(negedge clk);
        launch(32'd12, 32'd11, 0); track(0);
        launch(32'd7, 32'd6, 0); track(0);
        chk("b2b_value", MulAns, 64'h2A);
        @(negedge clk);
        launch(32'hFFFFFF00, 32'h00000123, 1); track(10);
        chk("ignored_start_value", MulAns, 64'hFFFFFFFFFFFEDD00);
        @(negedge clk);
        launch(32'd9, 32'd9, 0);
        repeat (10) @(negedge clk);
        reset = 0;
        #1;
        chk("async_reset", {busy, done, MulAns[61:0]}, 64'd0);
        chk("async_reset_hi", {62'd0, MulAns[63:62]}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        launch(32'd2, 32'd2, 0); track(0);
        chk("post_reset_value", MulAns, 64'd4);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_value", MulAns, last_exp);
            chk("hold_idle", {62'd0, busy, done}, 64'd0);
        end
        for (int n = 0; n < 20; n++) begin
            launch($urandom, $urandom, 1'($urandom_range(0, 1)));
            track(0);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
